// File: rtl/input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// input_debounce_pkg
// Shared types and constants for the input_debounce block.
//   db_state_t  : debounce FSM state encoding
//   GLITCH_MAX  : saturation value of the rejected-glitch counter
// -----------------------------------------------------------------------------
package input_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } db_state_t;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage : input_debounce_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchroniser for a single asynchronous bit.
//   clk    in  : destination clock, rising edge
//   rst_n  in  : asynchronous active-low reset, loads RESET_VAL into every stage
//   d      in  : asynchronous input
//   q      out : synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    // Stage 0 captures the raw input; every later stage copies its predecessor.
    assign stage_d[0] = d;
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        assign stage_d[gi] = stage_q[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {STAGES{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
// Synchronises an asynchronous input, rejects pulses shorter than
// DEBOUNCE_CYCLES samples, and emits a clean level with one-cycle rise/fall
// strobes. Rejected transitions are counted (saturating) for debug.
//   clk           in  : single clock, rising edge
//   rst_n         in  : asynchronous active-low reset
//   raw           in  : asynchronous input (pin / button)
//   clear_glitch  in  : synchronous clear of glitch_cnt (wins over increment)
//   level         out : debounced level (registered)
//   rise          out : one-cycle pulse in the first cycle level reads 1
//   fall          out : one-cycle pulse in the first cycle level reads 0
//   glitch_cnt    out : rejected-transition count, saturates at 255
// -----------------------------------------------------------------------------
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  logic       clear_glitch,
    output logic       level,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("input_debounce: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
    end

    logic s;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw),
        .q     (s)
    );

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       glitch_q, glitch_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_evt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        glitch_evt = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    state_d    = STABLE_LO;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // This edge supplies the DEBOUNCE_CYCLES-th agreeing sample.
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LO: begin
                if (s) begin
                    state_d    = STABLE_HI;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
            end
        endcase

        // Level follows the next state so it lines up with the state register;
        // strobes compare it against the current registered level.
        level_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;

        if (clear_glitch) begin
            glitch_d = 8'd0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 8'd1;
        end else begin
            glitch_d = glitch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (RESET_LEVEL) begin
                state_q <= STABLE_HI;
            end else begin
                state_q <= STABLE_LO;
            end
            cnt_q    <= '0;
            glitch_q <= 8'd0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;

endmodule : input_debounce
